// File: rtl/alu_arb.sv
// Two-requester front end for a shared combinational ALU: grants one request at a time,
// sequences it through the ALU for one cycle and holds the result until the owner takes it.
module alu_arb #(
   parameter int unsigned RR_EN = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [63:0] req0_a,
   input  logic [63:0] req0_b,
   input  logic [3:0]  req0_func,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [63:0] req1_a,
   input  logic [63:0] req1_b,
   input  logic [3:0]  req1_func,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [63:0] rsp0_data,
   output logic        rsp0_err,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [63:0] rsp1_data,
   output logic        rsp1_err,
   output logic [63:0] alu_a,
   output logic [63:0] alu_b,
   output logic [3:0]  alu_func,
   input  logic [63:0] alu_out
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state;
   logic        ptr;
   logic        owner;
   logic [63:0] a_q;
   logic [63:0] b_q;
   logic [3:0]  func_q;
   logic [63:0] res_q;
   logic        err_q;

   logic        grant;
   logic        accept;
   logic        func_ok;
   logic        owner_ready;

   always_comb begin
      func_ok = 1'b0;
      unique case (func_q)
         4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
         4'b0101, 4'b1101, 4'b0110, 4'b0111, 4'b1110: func_ok = 1'b1;
         default: func_ok = 1'b0;
      endcase
   end

   always_comb begin
      grant = req1_valid;
      if (req0_valid && req1_valid) begin
         grant = (RR_EN != 0) ? ptr : 1'b0;
      end
   end

   // ready is gated by rst_n so it reads 0 while reset is held, even with valid high
   assign accept      = (state == IDLE) && (req0_valid || req1_valid);
   assign req0_ready  = rst_n && accept && !grant;
   assign req1_ready  = rst_n && accept && grant;
   assign owner_ready = owner ? rsp1_ready : rsp0_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         ptr    <= 1'b0;
         owner  <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         func_q <= '0;
         res_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  a_q    <= grant ? req1_a : req0_a;
                  b_q    <= grant ? req1_b : req0_b;
                  func_q <= grant ? req1_func : req0_func;
                  owner  <= grant;
                  if (RR_EN != 0) begin
                     ptr <= !grant;
                  end
                  state  <= EXEC;
               end
            end
            EXEC: begin
               res_q <= func_ok ? alu_out : '0;
               err_q <= !func_ok;
               state <= RESP;
            end
            RESP: begin
               if (owner_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign alu_a    = (state == EXEC) ? a_q : '0;
   assign alu_b    = (state == EXEC) ? b_q : '0;
   assign alu_func = (state == EXEC) ? func_q : 4'b0000;

   assign rsp0_valid = (state == RESP) && !owner;
   assign rsp1_valid = (state == RESP) && owner;
   assign rsp0_data  = rsp0_valid ? res_q : '0;
   assign rsp1_data  = rsp1_valid ? res_q : '0;
   assign rsp0_err   = rsp0_valid && err_q;
   assign rsp1_err   = rsp1_valid && err_q;

endmodule

// File: tb/tb_alu_arb.sv
// Directed bench for alu_arb: a round-robin and a fixed-priority instance share stimulus,
// each backed by a behavioural model of the shared ALU.
module tb_alu_arb;

   logic clk;
   logic rst_n;

   logic [1:0]        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
   logic [1:0][63:0]  req_a, req_b, rsp_data;
   logic [1:0][3:0]   req_func;
   logic [63:0]       alu_a, alu_b, alu_out;
   logic [3:0]        alu_func;

   logic [1:0]        fp_req_ready, fp_rsp_valid, fp_rsp_err;
   logic [1:0][63:0]  fp_rsp_data;
   logic [63:0]       fp_alu_a, fp_alu_b, fp_alu_out;
   logic [3:0]        fp_alu_func;

   int tests;
   int fails;

   typedef struct {
      logic        k;
      logic [63:0] a;
      logic [63:0] b;
      logic [3:0]  f;
      logic [63:0] d;
      logic        e;
   } vec_t;

   vec_t vecs[14];

   function automatic logic [63:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                             input logic [3:0] f);
      case (f)
         4'b0000: return a + b;
         4'b1000: return a - b;
         4'b0001: return a << b[4:0];
         4'b0010: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
         4'b0011: return (a < b) ? 64'd1 : 64'd0;
         4'b0100: return a ^ b;
         4'b0101: return a >> b[4:0];
         4'b1101: return $unsigned($signed(a) >>> b[4:0]);
         4'b0110: return a | b;
         4'b0111: return a & b;
         4'b1110: return a & ~b;
         default: return a ^ b ^ 64'hdead_beef_1234_5678;
      endcase
   endfunction

   assign alu_out    = alu_model(alu_a, alu_b, alu_func);
   assign fp_alu_out = alu_model(fp_alu_a, fp_alu_b, fp_alu_func);

   alu_arb #(.RR_EN(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req_valid[0]),
      .req0_ready (req_ready[0]),
      .req0_a     (req_a[0]),
      .req0_b     (req_b[0]),
      .req0_func  (req_func[0]),
      .req1_valid (req_valid[1]),
      .req1_ready (req_ready[1]),
      .req1_a     (req_a[1]),
      .req1_b     (req_b[1]),
      .req1_func  (req_func[1]),
      .rsp0_valid (rsp_valid[0]),
      .rsp0_ready (rsp_ready[0]),
      .rsp0_data  (rsp_data[0]),
      .rsp0_err   (rsp_err[0]),
      .rsp1_valid (rsp_valid[1]),
      .rsp1_ready (rsp_ready[1]),
      .rsp1_data  (rsp_data[1]),
      .rsp1_err   (rsp_err[1]),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_func   (alu_func),
      .alu_out    (alu_out)
   );

   alu_arb #(.RR_EN(0)) dut_fp (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req_valid[0]),
      .req0_ready (fp_req_ready[0]),
      .req0_a     (req_a[0]),
      .req0_b     (req_b[0]),
      .req0_func  (req_func[0]),
      .req1_valid (req_valid[1]),
      .req1_ready (fp_req_ready[1]),
      .req1_a     (req_a[1]),
      .req1_b     (req_b[1]),
      .req1_func  (req_func[1]),
      .rsp0_valid (fp_rsp_valid[0]),
      .rsp0_ready (rsp_ready[0]),
      .rsp0_data  (fp_rsp_data[0]),
      .rsp0_err   (fp_rsp_err[0]),
      .rsp1_valid (fp_rsp_valid[1]),
      .rsp1_ready (rsp_ready[1]),
      .rsp1_data  (fp_rsp_data[1]),
      .rsp1_err   (fp_rsp_err[1]),
      .alu_a      (fp_alu_a),
      .alu_b      (fp_alu_b),
      .alu_func   (fp_alu_func),
      .alu_out    (fp_alu_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Starts and ends on a falling edge with the DUT in IDLE.
   task automatic run_op(input vec_t v);
      int n;
      req_a[v.k]     = v.a;
      req_b[v.k]     = v.b;
      req_func[v.k]  = v.f;
      req_valid[v.k] = 1'b1;
      #1;
      n = 0;
      while (!req_ready[v.k] && n < 8) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("req_ready", req_ready[v.k], 1);
      chk("other_ready", req_ready[!v.k], 0);
      @(posedge clk);
      @(negedge clk);
      req_valid[v.k] = 1'b0;
      chk("exec_alu_a", alu_a, v.a);
      chk("exec_alu_b", alu_b, v.b);
      chk("exec_alu_func", alu_func, v.f);
      chk("exec_no_rsp", rsp_valid[v.k], 0);
      @(negedge clk);
      chk("rsp_valid", rsp_valid[v.k], 1);
      chk("rsp_other_valid", rsp_valid[!v.k], 0);
      chk("rsp_data", rsp_data[v.k], v.d);
      chk("rsp_err", rsp_err[v.k], v.e);
      chk("resp_alu_a_zero", alu_a, 0);
      @(negedge clk);
      chk("rsp_done", rsp_valid[v.k], 0);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      vecs[0]  = '{1'b0, 64'd5, 64'd3, 4'b1000, 64'd2, 1'b0};
      vecs[1]  = '{1'b1, 64'h8000_0000_0000_0000, 64'h24, 4'b1101,
                   64'hF800_0000_0000_0000, 1'b0};
      vecs[2]  = '{1'b0, 64'd5, 64'd3, 4'b1111, 64'd0, 1'b1};
      vecs[3]  = '{1'b1, 64'd7, 64'd5, 4'b0000, 64'd12, 1'b0};
      vecs[4]  = '{1'b0, 64'd1, 64'h3F, 4'b0001, 64'h8000_0000, 1'b0};
      vecs[5]  = '{1'b1, 64'hF0, 64'h3C, 4'b0100, 64'hCC, 1'b0};
      vecs[6]  = '{1'b0, 64'hF0, 64'h3C, 4'b0111, 64'h30, 1'b0};
      vecs[7]  = '{1'b1, 64'hF0, 64'h3C, 4'b0110, 64'hFC, 1'b0};
      vecs[8]  = '{1'b1, 64'hF0, 64'h3C, 4'b1001, 64'd0, 1'b1};
      vecs[9]  = '{1'b0, '1, 64'd1, 4'b0010, 64'd1, 1'b0};
      vecs[10] = '{1'b0, '1, 64'd1, 4'b0011, 64'd0, 1'b0};
      vecs[11] = '{1'b1, 64'h8000_0000_0000_0000, 64'd4, 4'b0101,
                   64'h0800_0000_0000_0000, 1'b0};
      vecs[12] = '{1'b0, 64'hF0, 64'h3C, 4'b1110, 64'hC0, 1'b0};
      vecs[13] = '{1'b1, 64'd5, 64'd3, 4'b1000, 64'd2, 1'b0};

      // Reset: ready stays low even with a valid request present
      rst_n     = 1'b0;
      req_valid = 2'b01;
      req_a     = '0;
      req_b     = '0;
      req_func  = '0;
      rsp_ready = 2'b11;
      #1;
      chk("reset_ready0", req_ready[0], 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_err", rsp_err, 0);
      chk("reset_rsp_data0", rsp_data[0], 0);
      chk("reset_alu_a", alu_a, 0);
      @(negedge clk);
      @(negedge clk);
      req_valid = 2'b00;
      rst_n     = 1'b1;

      for (int i = 0; i < 14; i++) begin
         run_op(vecs[i]);
      end

      // Both requesters valid every cycle: RR alternates, fixed priority sticks to 0
      rst_n = 1'b0;
      @(negedge clk);
      rst_n       = 1'b1;
      req_a[0]    = 64'd1;
      req_b[0]    = 64'd1;
      req_func[0] = 4'b0000;
      req_a[1]    = 64'd10;
      req_b[1]    = 64'd1;
      req_func[1] = 4'b0000;
      req_valid   = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_grant0", req_ready[0], (i % 2) == 0);
         chk("rr_grant1", req_ready[1], (i % 2) == 1);
         chk("fp_grant0", fp_req_ready[0], 1);
         chk("fp_grant1", fp_req_ready[1], 0);
         @(posedge clk);
         @(negedge clk);
         @(negedge clk);
         chk("rr_rsp_owner", rsp_valid[i % 2], 1);
         chk("rr_rsp_data", rsp_data[i % 2], ((i % 2) == 1) ? 64'd11 : 64'd2);
         chk("fp_rsp_data", fp_rsp_data[0], 64'd2);
         @(negedge clk);
      end
      req_valid = 2'b00;
      @(negedge clk);

      // Response backpressure on requester 0 while requester 1 waits
      rsp_ready[0] = 1'b0;
      req_a[0]     = 64'd9;
      req_b[0]     = 64'd4;
      req_func[0]  = 4'b1000;
      req_valid[0] = 1'b1;
      #1;
      chk("bp_ready0", req_ready[0], 1);
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      req_a[1]     = 64'd3;
      req_b[1]     = 64'd4;
      req_func[1]  = 4'b0000;
      req_valid[1] = 1'b1;
      #1;
      chk("bp_exec_ready1", req_ready[1], 0);
      @(negedge clk);
      for (int j = 0; j < 5; j++) begin
         chk("bp_hold_valid", rsp_valid[0], 1);
         chk("bp_hold_data", rsp_data[0], 64'd5);
         chk("bp_hold_ready1", req_ready[1], 0);
         @(negedge clk);
      end
      rsp_ready[0] = 1'b1;
      #1;
      chk("bp_hs_valid", rsp_valid[0], 1);
      chk("bp_hs_ready1", req_ready[1], 0);
      @(negedge clk);
      #1;
      chk("bp_idle_ready1", req_ready[1], 1);
      chk("bp_idle_rsp0", rsp_valid[0], 0);
      @(posedge clk);
      @(negedge clk);
      req_valid[1] = 1'b0;
      @(negedge clk);
      chk("bp_req1_valid", rsp_valid[1], 1);
      chk("bp_req1_data", rsp_data[1], 64'd7);
      @(negedge clk);

      // Reset during EXEC discards the operation
      req_a[0]     = 64'd1;
      req_b[0]     = 64'd2;
      req_func[0]  = 4'b0000;
      req_valid[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      chk("mid_exec_alu_b", alu_b, 64'd2);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk("rst_no_rsp", rsp_valid[0], 0);
         chk("rst_rsp_data", rsp_data[0], 0);
      end
      rst_n = 1'b1;
      run_op(vecs[3]);
      run_op(vecs[0]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no completion, expected finish");
      $fatal(1, "timeout");
   end

endmodule
